darkio: RTL and testbench
=========================

# darkio

Memory-mapped I/O block on the darkriscv data bus, in parallel with `memory`.
- Claims every access with `DADDR[31]==1`; `memory` ignores those writes.
- Provides a board-ID register, a UART transmitter with a 4-entry FIFO, a LED register, and a periodic timer with interrupt flags.
- Returns read data with one wait state, the same protocol as `memory`, and raises its own halt when a transaction cannot complete.

## Interface
Parameters:
- `BAUD_DIV`, 868, clock cycles per UART bit (≥2).
- `BOARD_ID`, 32'h0, value returned by the ID register.

Ports:
- `CLK`  in  1  system clock; all state on rising edge.
- `RES`  in  1  reset, asynchronous, active-low (0 = reset).
- `DADDR`  in  32  data address; the block is selected when `DADDR[31]==1`; register index is `DADDR[4:2]`.
- `DATAI`  in  32  write data.
- `WR`  in  1  write strobe.
- `RD`  in  1  read strobe.
- `BE`  in  4  byte enables for writes.
- `IODATAO`  out  32  registered read data.
- `IOHLT`  out  1  combinational stall request; the top level ORs it into `HLT`.
- `IRQ`  out  1  OR of pending interrupt flags, registered.
- `TXD`  out  1  UART serial output, idle high.
- `LED`  out  16  LED register.

## Operation
Selection: `SEL = DADDR[31] & (RD | WR)`. If `SEL` is 0, the block has no effect on any register.

Register map, indexed by `DADDR[4:2]`:
- 0 ID: read-only; reads `BOARD_ID`.
- 1 UART:
  - Read: bit 9 = FIFO full; bit 8 = busy (FIFO non-empty or shifter active); other bits 0.
  - Write with `BE[0]`: push `DATAI[7:0]`.
- 2 LED: read/write `[15:0]`; `BE[0]` and `BE[1]` enable their byte lanes; upper bits read as 0.
- 3 PERIOD: read/write, 32 bits; each byte written only if its `BE` bit is set. Any write to PERIOD clears COUNT to 0 in the same edge.
- 4 COUNT: read-only.
- 5 IRQF:
  - bit 0 = timer flag; bit 1 = TX-done flag.
  - Write with `BE[0]`: write-1-to-clear on `DATAI[1:0]`.
- 6, 7: read as 0; writes are ignored.

Timer:
- If PERIOD==0: COUNT is held at 0 and never sets the flag.
- Otherwise COUNT increments every cycle. When COUNT==PERIOD, the next edge sets COUNT to 0 and sets flag bit 0.
- If a set event and a W1C of the same bit occur in the same cycle, the set wins.

UART TX:
- Frame is 8N1, LSB first: start bit 0, 8 data bits, stop bit 1. Each bit lasts exactly `BAUD_DIV` cycles.
- Shifter states: IDLE → START → DATA (bit index 0..7) → STOP → IDLE.
- In IDLE with the FIFO non-empty, the shifter pops the head entry and enters START on the next edge.
- At the end of STOP:
  - If the FIFO is non-empty, go directly to START with the next byte; there is no idle gap.
  - Otherwise go to IDLE and set flag bit 1.
- FIFO: 4 entries with wrap-around read/write pointers and a 3-bit occupancy count.
- A push and a pop in the same cycle leave the occupancy unchanged.

## Timing
Read handshake (`RD & DADDR[31]`), using a 1-bit `RACK` register:
- Cycle N (`RACK==0`): `IOHLT=1`. The edge sets `RACK<=1` and `IODATAO<=register[DADDR[4:2]]`.
- Cycle N+1 (`RACK==1`): `IOHLT=0` and `IODATAO` is valid. The edge sets `RACK<=0`.
- Read latency is 1 wait state.

Writes:
- Zero wait states; commit at the edge ending the cycle.
- Exception: a UART push while the FIFO is full holds `IOHLT=1` and performs no push until a pop frees a slot.
  - In that cycle `IOHLT` drops, and the push commits at that edge.
  - A pop and a stalled push in the same cycle are therefore legal.

Other timing:
- `IRQ` is registered: it equals `|IRQF` delayed by one cycle.
- `IOHLT` is asserted only when the block is selected.

Reset (`RES` low), asynchronous:
- `IODATAO=0`, `RACK=0`, `IRQ=0`, `IRQF=0`, `LED=0`, `PERIOD=0`, `COUNT=0`.
- FIFO is emptied; shifter goes to IDLE; `TXD=1`.
- A frame in progress is aborted immediately, with no stop bit.
- Release is synchronous to the next rising edge.

## Test plan
- Reset with `TXD=1`, then read ID with `BOARD_ID=32'hDA4C0001` → `IOHLT` high for 1 cycle, then `IODATAO=32'hDA4C0001` with `IOHLT` low.
- Write LED `DATAI=32'hFFFF_A55A`, `BE=4'b0001` → `LED=16'h005A`. Then write with `BE=4'b0010` → `LED=16'hA55A`. Read back → `32'h0000A55A`.
- Write PERIOD=4, wait → COUNT sequence 0,1,2,3,4,0. Flag bit 0 set on the wrap, and `IRQ` rises one cycle later. W1C `DATAI=1` → flag clears, `IRQ` falls.
- `BAUD_DIV=4`, push `8'h55` → `TXD` is 0 for 4 cycles, then bits 1,0,1,0,1,0,1,0 at 4 cycles each, then 1. Flag bit 1 set after the stop bit.
- Push 6 bytes back-to-back → the 6th push stalls (`IOHLT=1`) until the first pop. Frames are contiguous with no idle gap, and all 6 bytes appear in push order.
- Assert `RES` mid-frame → `TXD=1` immediately, FIFO empty, UART status reads 0 after release.

Source files
------------

// File: rtl/darkio.sv
// darkio: memory-mapped I/O on the darkriscv data bus (board ID, UART TX with 4-deep FIFO, LEDs, timer).
// Reads return after one wait state; a push into a full UART FIFO stalls the core through IOHLT.
module darkio #(
    parameter int unsigned BAUD_DIV = 868,
    parameter logic [31:0] BOARD_ID = 32'h0
) (
    input  logic        CLK,
    input  logic        RES,
    input  logic [31:0] DADDR,
    input  logic [31:0] DATAI,
    input  logic        WR,
    input  logic        RD,
    input  logic [3:0]  BE,
    output logic [31:0] IODATAO,
    output logic        IOHLT,
    output logic        IRQ,
    output logic        TXD,
    output logic [15:0] LED
);
    localparam int BW = $clog2(BAUD_DIV);
    localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);

    // IDLE: wait for FIFO data | START: start bit | DATA: bits 0..7 | STOP: stop bit
    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

    logic [2:0]    idx;
    logic          rd_sel, wr_sel;
    logic          rack_q;
    logic [31:0]   iodatao_q, rdata;
    logic [15:0]   led_q;
    logic [31:0]   period_q, count_q;
    logic [1:0]    irqf_q, irqf_clr;
    logic          irq_q;
    logic [7:0]    fifo_q [4];
    logic [1:0]    wptr_q, rptr_q;
    logic [2:0]    fcnt_q;
    tx_state_t     tx_state_q;
    logic [BW-1:0] baud_q;
    logic [2:0]    bit_q;
    logic [7:0]    shreg_q;
    logic          txd_q;
    logic          fifo_full, fifo_empty, tx_busy, bit_end;
    logic          pop, push_req, push, push_stall, tx_done;
    logic          period_wr, tmr_evt;
    logic          unused_addr;

    assign idx         = DADDR[4:2];
    assign rd_sel      = DADDR[31] & RD;
    assign wr_sel      = DADDR[31] & WR;
    assign unused_addr = ^{DADDR[30:5], DADDR[1:0]};

    assign fifo_full  = (fcnt_q == 3'd4);
    assign fifo_empty = (fcnt_q == 3'd0);
    assign tx_busy    = ~fifo_empty | (tx_state_q != TX_IDLE);
    assign bit_end    = (baud_q == '0);
    assign pop        = ~fifo_empty & ((tx_state_q == TX_IDLE) | ((tx_state_q == TX_STOP) & bit_end));
    assign tx_done    = fifo_empty & (tx_state_q == TX_STOP) & bit_end;

    // A pop in the same cycle frees a slot, so a stalled push may commit alongside it.
    assign push_req   = wr_sel & (idx == 3'd1) & BE[0];
    assign push       = push_req & (~fifo_full | pop);
    assign push_stall = push_req & fifo_full & ~pop;
    assign IOHLT      = (rd_sel & ~rack_q) | push_stall;

    assign period_wr = wr_sel & (idx == 3'd3);
    assign tmr_evt   = ~period_wr & (period_q != '0) & (count_q == period_q);
    assign irqf_clr  = (wr_sel & (idx == 3'd5) & BE[0]) ? DATAI[1:0] : 2'b00;

    always_comb begin
        rdata = '0;
        case (idx)
            3'd0:    rdata = BOARD_ID;
            3'd1:    rdata = {22'd0, fifo_full, tx_busy, 8'd0};
            3'd2:    rdata = {16'd0, led_q};
            3'd3:    rdata = period_q;
            3'd4:    rdata = count_q;
            3'd5:    rdata = {30'd0, irqf_q};
            default: rdata = '0;
        endcase
    end

    always_ff @(posedge CLK or negedge RES) begin
        if (!RES) begin
            rack_q    <= 1'b0;
            iodatao_q <= '0;
            led_q     <= '0;
            period_q  <= '0;
            count_q   <= '0;
            irqf_q    <= '0;
            irq_q     <= 1'b0;
        end else begin
            if (rd_sel & ~rack_q) begin
                rack_q    <= 1'b1;
                iodatao_q <= rdata;
            end else begin
                rack_q <= 1'b0;
            end
            if (wr_sel & (idx == 3'd2)) begin
                if (BE[0]) led_q[7:0]  <= DATAI[7:0];
                if (BE[1]) led_q[15:8] <= DATAI[15:8];
            end
            if (period_wr) begin
                for (int b = 0; b < 4; b++)
                    if (BE[b]) period_q[8*b +: 8] <= DATAI[8*b +: 8];
                count_q <= '0;
            end else if (period_q == '0 || tmr_evt) begin
                count_q <= '0;
            end else begin
                count_q <= count_q + 32'd1;
            end
            irqf_q <= (irqf_q & ~irqf_clr) | {tx_done, tmr_evt};
            irq_q  <= |irqf_q;
        end
    end

    always_ff @(posedge CLK or negedge RES) begin
        if (!RES) begin
            for (int i = 0; i < 4; i++) fifo_q[i] <= '0;
            wptr_q <= '0;
            rptr_q <= '0;
            fcnt_q <= '0;
        end else begin
            if (push) begin
                fifo_q[wptr_q] <= DATAI[7:0];
                wptr_q         <= wptr_q + 2'd1;
            end
            if (pop) rptr_q <= rptr_q + 2'd1;
            case ({push, pop})
                2'b10:   fcnt_q <= fcnt_q + 3'd1;
                2'b01:   fcnt_q <= fcnt_q - 3'd1;
                default: fcnt_q <= fcnt_q;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RES) begin
        if (!RES) begin
            tx_state_q <= TX_IDLE;
            baud_q     <= '0;
            bit_q      <= '0;
            shreg_q    <= '0;
            txd_q      <= 1'b1;
        end else begin
            case (tx_state_q)
                TX_IDLE: begin
                    if (pop) begin
                        tx_state_q <= TX_START;
                        shreg_q    <= fifo_q[rptr_q];
                        baud_q     <= BAUD_LAST;
                        txd_q      <= 1'b0;
                    end
                end
                TX_START: begin
                    if (bit_end) begin
                        tx_state_q <= TX_DATA;
                        bit_q      <= '0;
                        baud_q     <= BAUD_LAST;
                        txd_q      <= shreg_q[0];
                    end else begin
                        baud_q <= baud_q - 1'b1;
                    end
                end
                TX_DATA: begin
                    if (bit_end) begin
                        baud_q <= BAUD_LAST;
                        if (bit_q == 3'd7) begin
                            tx_state_q <= TX_STOP;
                            txd_q      <= 1'b1;
                        end else begin
                            bit_q   <= bit_q + 1'b1;
                            shreg_q <= shreg_q >> 1;
                            txd_q   <= shreg_q[1];
                        end
                    end else begin
                        baud_q <= baud_q - 1'b1;
                    end
                end
                TX_STOP: begin
                    if (bit_end) begin
                        if (pop) begin
                            tx_state_q <= TX_START;
                            shreg_q    <= fifo_q[rptr_q];
                            baud_q     <= BAUD_LAST;
                            txd_q      <= 1'b0;
                        end else begin
                            tx_state_q <= TX_IDLE;
                        end
                    end else begin
                        baud_q <= baud_q - 1'b1;
                    end
                end
                default: tx_state_q <= TX_IDLE;
            endcase
        end
    end

    assign IODATAO = iodatao_q;
    assign IRQ     = irq_q;
    assign TXD     = txd_q;
    assign LED     = led_q;
endmodule

// File: tb/tb_darkio.sv
// Self-checking bench for darkio: bus tasks, a UART frame receiver, and cycle-count timing models.
module tb_darkio;
    localparam int BAUD = 4;
    localparam int FRAME = 10 * BAUD;
    localparam logic [31:0] BID = 32'hDA4C0001;

    logic        CLK = 1'b0, RES = 1'b0;
    logic [31:0] DADDR = '0, DATAI = '0;
    logic        WR = 1'b0, RD = 1'b0;
    logic [3:0]  BE = '0;
    logic [31:0] IODATAO;
    logic        IOHLT, IRQ, TXD;
    logic [15:0] LED;

    int cyc = 0;
    int n_tests = 0, n_fail = 0;

    logic [7:0] rx_q [$];
    int         rx_start [$];
    int         frame_bad = 0;
    logic [9:0] mon_lv;
    int         mon_s;
    logic       mon_ab, mon_bad;

    darkio #(.BAUD_DIV(BAUD), .BOARD_ID(BID)) dut (
        .CLK(CLK), .RES(RES), .DADDR(DADDR), .DATAI(DATAI), .WR(WR), .RD(RD), .BE(BE),
        .IODATAO(IODATAO), .IOHLT(IOHLT), .IRQ(IRQ), .TXD(TXD), .LED(LED)
    );

    initial forever #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    // UART receiver: each bit must hold for BAUD samples; frames cut by reset are dropped.
    always begin
        @(negedge CLK);
        if (RES === 1'b1 && TXD === 1'b0) begin
            mon_s = cyc; mon_ab = 1'b0; mon_bad = 1'b0; mon_lv = '0;
            for (int k = 0; k < FRAME; k++) begin
                if (k > 0) @(negedge CLK);
                if (RES !== 1'b1) begin mon_ab = 1'b1; break; end
                if (k % BAUD == 0) mon_lv[k / BAUD] = TXD;
                else if (TXD !== mon_lv[k / BAUD]) mon_bad = 1'b1;
            end
            if (!mon_ab) begin
                if (mon_lv[0] !== 1'b0 || mon_lv[9] !== 1'b1) mon_bad = 1'b1;
                if (mon_bad) frame_bad++;
                rx_q.push_back(mon_lv[8:1]);
                rx_start.push_back(mon_s);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1);
    end

    function automatic logic [31:0] ra(input logic [2:0] i);
        return {1'b1, 26'h0, i, 2'b00};
    endfunction

    task automatic bus_write(input logic [31:0] addr, input logic [31:0] d, input logic [3:0] be,
                             output int stall, output int ccyc);
        @(negedge CLK);
        DADDR = addr; DATAI = d; BE = be; WR = 1'b1;
        stall = 0;
        #1;
        while (IOHLT === 1'b1 && stall < 2000) begin
            @(posedge CLK); #1;
            stall++;
        end
        @(posedge CLK); #1;
        ccyc = cyc;
        WR = 1'b0; DADDR = '0; DATAI = '0; BE = '0;
    endtask

    task automatic bus_read(input logic [2:0] i, output logic [31:0] d, output logic h0,
                            output logic h1, output int ccyc);
        @(negedge CLK);
        DADDR = ra(i); RD = 1'b1;
        #1;
        h0 = IOHLT;
        @(posedge CLK); #1;
        ccyc = cyc; h1 = IOHLT; d = IODATAO;
        RD = 1'b0; DADDR = '0;
        @(posedge CLK); #1;
    endtask

    function automatic bit wrapped(input int a, input int b, input int cw, input int p);
        for (int w = a; w <= b; w++)
            if (w > cw && (w - cw) % (p + 1) == 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic test_reset();
        RES = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        n_tests++; if (TXD !== 1'b1) begin n_fail++; $display("FAIL reset_txd: got %b want 1", TXD); end
        n_tests++; if (IODATAO !== 32'h0) begin n_fail++; $display("FAIL reset_iodatao: got %h want 0", IODATAO); end
        n_tests++; if (IRQ !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %b want 0", IRQ); end
        n_tests++; if (LED !== 16'h0) begin n_fail++; $display("FAIL reset_led: got %h want 0", LED); end
        n_tests++; if (IOHLT !== 1'b0) begin n_fail++; $display("FAIL reset_iohlt: got %b want 0", IOHLT); end
        @(negedge CLK);
        RES = 1'b1;
        @(posedge CLK); #1;
    endtask

    task automatic test_id();
        logic [31:0] d; logic h0, h1; int ce, st, c;
        bus_read(3'd0, d, h0, h1, ce);
        n_tests++; if (h0 !== 1'b1) begin n_fail++; $display("FAIL id_wait: IOHLT got %b want 1", h0); end
        n_tests++; if (h1 !== 1'b0) begin n_fail++; $display("FAIL id_ready: IOHLT got %b want 0", h1); end
        n_tests++; if (d !== BID) begin n_fail++; $display("FAIL id_data: got %h want %h", d, BID); end
        bus_write(ra(3'd6), 32'hFFFF_FFFF, 4'hF, st, c);
        for (int i = 6; i < 8; i++) begin
            bus_read(3'(i), d, h0, h1, ce);
            n_tests++; if (d !== 32'h0) begin n_fail++; $display("FAIL unmapped_%0d: got %h want 0", i, d); end
        end
    endtask

    task automatic test_led();
        logic [31:0] d, wd; logic h0, h1; logic [3:0] be; logic [15:0] led_m;
        int ce, st, c; bit sel;
        bus_write(ra(3'd2), 32'hFFFF_A55A, 4'b0001, st, c);
        n_tests++; if (LED !== 16'h005A) begin n_fail++; $display("FAIL led_lane0: got %h want 005a", LED); end
        bus_write(ra(3'd2), 32'hFFFF_A55A, 4'b0010, st, c);
        n_tests++; if (LED !== 16'hA55A) begin n_fail++; $display("FAIL led_lane1: got %h want a55a", LED); end
        bus_read(3'd2, d, h0, h1, ce);
        n_tests++; if (d !== 32'h0000A55A) begin n_fail++; $display("FAIL led_read: got %h want 0000a55a", d); end
        led_m = 16'hA55A;
        for (int i = 0; i < 10; i++) begin
            wd  = $urandom;
            be  = 4'($urandom_range(0, 15));
            sel = ($urandom_range(0, 3) != 0);
            bus_write(sel ? ra(3'd2) : {1'b0, 26'h0, 3'd2, 2'b00}, wd, be, st, c);
            if (sel && be[0]) led_m[7:0]  = wd[7:0];
            if (sel && be[1]) led_m[15:8] = wd[15:8];
            n_tests++; if (LED !== led_m) begin n_fail++; $display("FAIL led_rand_%0d: got %h want %h", i, LED, led_m); end
            bus_read(3'd2, d, h0, h1, ce);
            n_tests++; if (d !== {16'h0, led_m}) begin n_fail++; $display("FAIL led_rb_%0d: got %h want %h", i, d, {16'h0, led_m}); end
        end
    endtask

    task automatic test_timer();
        logic [31:0] d, period_m, wd; logic h0, h1; int ce, st, cw, c1, p;
        bit exp_irq;
        period_m = 32'd4;
        bus_write(ra(3'd3), period_m, 4'hF, st, cw);
        p = 4;
        for (int i = 0; i < 3 * (p + 1); i++) begin
            @(posedge CLK); #1;
            exp_irq = ((cyc - 1) >= cw + p + 1);
            n_tests++; if (IRQ !== exp_irq) begin n_fail++; $display("FAIL irq_trace_%0d: got %b want %b", i, IRQ, exp_irq); end
        end
        // Only the low byte lane is enabled; the upper bytes must keep their old value.
        wd = {24'hFFFFFF, 8'($urandom_range(1, 6))};
        bus_write(ra(3'd3), wd, 4'b0001, st, cw);
        period_m = {period_m[31:8], wd[7:0]};
        p = int'(period_m);
        bus_read(3'd3, d, h0, h1, ce);
        n_tests++; if (d !== period_m) begin n_fail++; $display("FAIL period_rb: got %h want %h", d, period_m); end
        for (int i = 0; i < 8; i++) begin
            repeat ($urandom_range(0, 2)) @(posedge CLK);
            bus_read(3'd4, d, h0, h1, ce);
            n_tests++;
            if (d !== 32'((ce - 1 - cw) % (p + 1))) begin
                n_fail++; $display("FAIL count_%0d: got %0d want %0d", i, d, (ce - 1 - cw) % (p + 1));
            end
        end
        bus_write(ra(3'd3), 32'h0, 4'hF, st, cw);
        repeat (5) @(posedge CLK);
        bus_read(3'd4, d, h0, h1, ce);
        n_tests++; if (d !== 32'h0) begin n_fail++; $display("FAIL count_held: got %0d want 0", d); end
        bus_write(ra(3'd5), 32'h3, 4'b0010, st, c1);
        bus_read(3'd5, d, h0, h1, ce);
        n_tests++; if (d !== 32'h1) begin n_fail++; $display("FAIL irqf_noclr: got %h want 1", d); end
        bus_write(ra(3'd5), 32'h1, 4'b0001, st, c1);
        n_tests++; if (IRQ !== 1'b1) begin n_fail++; $display("FAIL irq_hold: got %b want 1", IRQ); end
        @(posedge CLK); #1;
        n_tests++; if (IRQ !== 1'b0) begin n_fail++; $display("FAIL irq_fall: got %b want 0", IRQ); end
        bus_read(3'd5, d, h0, h1, ce);
        n_tests++; if (d !== 32'h0) begin n_fail++; $display("FAIL irqf_clr: got %h want 0", d); end
    endtask

    task automatic test_set_wins();
        logic [31:0] d; logic h0, h1; int ce, st, cw, c2, p, target; bit e;
        p = $urandom_range(2, 5);
        bus_write(ra(3'd3), 32'(p), 4'hF, st, cw);
        target = cw + 2 * (p + 1);
        while (cyc + 1 < target) begin @(posedge CLK); #1; end
        bus_write(ra(3'd5), 32'h1, 4'b0001, st, c2);
        bus_read(3'd5, d, h0, h1, ce);
        e = wrapped(c2, ce - 1, cw, p);
        n_tests++; if (d[0] !== e) begin n_fail++; $display("FAIL setwins: got %b want %b", d[0], e); end
        bus_write(ra(3'd5), 32'h1, 4'b0001, st, c2);
        bus_read(3'd5, d, h0, h1, ce);
        e = wrapped(c2, ce - 1, cw, p);
        n_tests++; if (d[0] !== e) begin n_fail++; $display("FAIL w1c_running: got %b want %b", d[0], e); end
        bus_write(ra(3'd3), 32'h0, 4'hF, st, c2);
        bus_write(ra(3'd5), 32'h1, 4'b0001, st, c2);
        bus_read(3'd5, d, h0, h1, ce);
        n_tests++; if (d !== 32'h0) begin n_fail++; $display("FAIL timer_stop_clr: got %h want 0", d); end
    endtask

    task automatic test_uart_single();
        logic [31:0] d, e; logic h0, h1; int ce, st, cp, fe, base, guard;
        base = rx_q.size();
        bus_write(ra(3'd1), 32'h0000_00AA, 4'b1110, st, cp);
        bus_read(3'd1, d, h0, h1, ce);
        n_tests++; if (d !== 32'h0) begin n_fail++; $display("FAIL uart_nobe0: got %h want 0", d); end
        bus_write(ra(3'd1), 32'h0000_0055, 4'b0001, st, cp);
        fe = cp + 1 + FRAME;
        guard = 0;
        while (cyc < fe + 3 && guard < 100) begin
            guard++;
            bus_read(3'd1, d, h0, h1, ce);
            e = ((ce - 1) >= cp && (ce - 1) < fe) ? 32'h100 : 32'h0;
            n_tests++; if (d !== e) begin n_fail++; $display("FAIL uart_busy_c%0d: got %h want %h", ce, d, e); end
            bus_read(3'd5, d, h0, h1, ce);
            e = ((ce - 1) >= fe) ? 32'h2 : 32'h0;
            n_tests++; if (d !== e) begin n_fail++; $display("FAIL txflag_c%0d: got %h want %h", ce, d, e); end
        end
        n_tests++;
        if (rx_q.size() != base + 1) begin
            n_fail++; $display("FAIL uart_frames: got %0d want %0d", rx_q.size() - base, 1);
        end else begin
            n_tests++; if (rx_q[base] !== 8'h55) begin n_fail++; $display("FAIL uart_byte: got %h want 55", rx_q[base]); end
            n_tests++; if (rx_start[base] != cp + 1) begin n_fail++; $display("FAIL uart_start: got %0d want %0d", rx_start[base], cp + 1); end
        end
        n_tests++; if (frame_bad != 0) begin n_fail++; $display("FAIL uart_shape: got %0d bad frames want 0", frame_bad); end
        n_tests++; if (TXD !== 1'b1) begin n_fail++; $display("FAIL uart_idle: got %b want 1", TXD); end
        bus_write(ra(3'd5), 32'h2, 4'b0001, st, cp);
        bus_read(3'd5, d, h0, h1, ce);
        n_tests++; if (d !== 32'h0) begin n_fail++; $display("FAIL txflag_clr: got %h want 0", d); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] b [6]; int stv [6]; int cpv [6];
        logic [31:0] d; logic h0, h1; int ce, st, c, base, guard;
        base = rx_q.size();
        for (int i = 0; i < 6; i++) b[i] = 8'($urandom);
        for (int i = 0; i < 6; i++) bus_write(ra(3'd1), {24'h0, b[i]}, 4'b0001, stv[i], cpv[i]);
        for (int i = 0; i < 5; i++) begin
            n_tests++; if (stv[i] != 0) begin n_fail++; $display("FAIL b2b_nostall_%0d: got %0d want 0", i, stv[i]); end
        end
        n_tests++; if (stv[5] == 0) begin n_fail++; $display("FAIL b2b_stall: got %0d stall cycles want >0", stv[5]); end
        n_tests++;
        if (cpv[5] != cpv[0] + 1 + FRAME) begin
            n_fail++; $display("FAIL b2b_release: got %0d want %0d", cpv[5], cpv[0] + 1 + FRAME);
        end
        guard = 0;
        while (rx_q.size() < base + 6 && guard < 8 * FRAME) begin @(posedge CLK); guard++; end
        n_tests++;
        if (rx_q.size() != base + 6) begin
            n_fail++; $display("FAIL b2b_frames: got %0d want 6", rx_q.size() - base);
        end else begin
            for (int i = 0; i < 6; i++) begin
                n_tests++; if (rx_q[base + i] !== b[i]) begin n_fail++; $display("FAIL b2b_byte_%0d: got %h want %h", i, rx_q[base + i], b[i]); end
                n_tests++;
                if (rx_start[base + i] != cpv[0] + 1 + i * FRAME) begin
                    n_fail++; $display("FAIL b2b_gap_%0d: got %0d want %0d", i, rx_start[base + i], cpv[0] + 1 + i * FRAME);
                end
            end
        end
        n_tests++; if (frame_bad != 0) begin n_fail++; $display("FAIL b2b_shape: got %0d bad frames want 0", frame_bad); end
        repeat (3) @(posedge CLK);
        bus_read(3'd5, d, h0, h1, ce);
        n_tests++; if (d !== 32'h2) begin n_fail++; $display("FAIL b2b_txflag: got %h want 2", d); end
        bus_write(ra(3'd5), 32'h2, 4'b0001, st, c);
    endtask

    task automatic test_reset_mid();
        logic [31:0] d; logic h0, h1; int ce, st, c, cp0, base;
        bus_write(ra(3'd2), 32'h0000_BEEF, 4'b0011, st, c);
        bus_write(ra(3'd3), 32'd7, 4'hF, st, c);
        base = rx_q.size();
        bus_write(ra(3'd1), 32'h0, 4'b0001, st, cp0);
        bus_write(ra(3'd1), 32'h12, 4'b0001, st, c);
        bus_write(ra(3'd1), 32'h34, 4'b0001, st, c);
        while (cyc < cp0 + 1 + 3 * BAUD) begin @(posedge CLK); #1; end
        n_tests++; if (TXD !== 1'b0) begin n_fail++; $display("FAIL mid_frame_txd: got %b want 0", TXD); end
        @(negedge CLK);
        RES = 1'b0;
        #1;
        n_tests++; if (TXD !== 1'b1) begin n_fail++; $display("FAIL rst_async_txd: got %b want 1", TXD); end
        n_tests++; if (LED !== 16'h0) begin n_fail++; $display("FAIL rst_async_led: got %h want 0", LED); end
        repeat (2) @(posedge CLK);
        #1;
        n_tests++; if (IRQ !== 1'b0) begin n_fail++; $display("FAIL rst_irq: got %b want 0", IRQ); end
        @(negedge CLK);
        RES = 1'b1;
        bus_read(3'd1, d, h0, h1, ce);
        n_tests++; if (d !== 32'h0) begin n_fail++; $display("FAIL rst_uart_status: got %h want 0", d); end
        bus_read(3'd3, d, h0, h1, ce);
        n_tests++; if (d !== 32'h0) begin n_fail++; $display("FAIL rst_period: got %h want 0", d); end
        repeat (2 * FRAME) @(posedge CLK);
        n_tests++; if (rx_q.size() != base) begin n_fail++; $display("FAIL rst_no_frames: got %0d want 0", rx_q.size() - base); end
        n_tests++; if (TXD !== 1'b1) begin n_fail++; $display("FAIL rst_txd_idle: got %b want 1", TXD); end
    endtask

    initial begin
        test_reset();
        test_id();
        test_led();
        test_timer();
        test_set_wins();
        test_uart_single();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
